// File: rtl/core_pkg.sv
// Shared register-file constants, types and scheduler state encoding.
// Optional forwarding build: define HAZARD_SCHED_FORWARD_EN to let ALU
// results (pending count 1) bypass through EX instead of stalling.
package core_pkg;

  localparam int NREG = 8;
  localparam int ADRW = 3;
  localparam int CNTW = 3;

`ifdef HAZARD_SCHED_FORWARD_EN
  // Only loads in flight (count >= 2) stall; ALU results are forwarded.
  localparam int HAZ_MIN = 2;
  localparam bit FWD_EN  = 1'b1;
`else
  // Any pending write stalls; no forwarding path.
  localparam int HAZ_MIN = 1;
  localparam bit FWD_EN  = 1'b0;
`endif

  typedef logic [ADRW-1:0]            reg_adr_t;
  typedef logic [CNTW-1:0]            cnt_t;
  typedef logic [NREG-1:0][CNTW-1:0]  cnt_vec_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } sched_state_t;

  // Pending count of one register out of the scoreboard vector.
  function automatic cnt_t pend_cnt(input cnt_vec_t vec, input reg_adr_t adr);
    return vec[adr];
  endfunction

endpackage

// File: rtl/hazard_chk.sv
// Per-operand check: does this source operand hazard, and is its producer
// an ALU result that becomes available through the EX forwarding path.
module hazard_chk
  import core_pkg::*;
(
  input  logic     use_i,
  input  reg_adr_t adr_i,
  input  cnt_vec_t cnt_vec_i,
  output logic     haz_o,
  output logic     alu_pend_o
);

  cnt_t cnt;

  // Look up the pending count and classify it against the stall threshold.
  always_comb begin
    cnt        = pend_cnt(cnt_vec_i, adr_i);
    haz_o      = use_i && (cnt >= cnt_t'(HAZ_MIN));
    alu_pend_o = use_i && (cnt == cnt_t'(1));
  end

endmodule

// File: rtl/hazard_sched.sv
// Decode-stage issue scheduler: issue, stall IF/ID, or flush after a taken
// branch, and mark the scoreboard only for instructions that really issue.
// Build option: HAZARD_SCHED_FORWARD_EN (see core_pkg) enables forwarding.
//
// Handshake: the ID instruction is consumed on a cycle with issue=1; while
// stall_id=1 it stays in ID unchanged and is re-evaluated next cycle; while
// flush_decode=1 it is squashed and never marks the scoreboard.
module hazard_sched
  import core_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 7,
  parameter int PERFW        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_rs_use,
  input  reg_adr_t         id_rs_adr,
  input  logic             id_rt_use,
  input  reg_adr_t         id_rt_adr,
  input  logic             id_regwrite,
  input  logic             id_from_mem,
  input  reg_adr_t         id_rd_adr,
  input  logic             branch_taken,
  input  cnt_vec_t         register_invalid,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_decode,
  output logic             issue,
  output logic             regwrite_cur,
  output logic             from_main_mem_id,
  output reg_adr_t         regwrite_adr_id,
  output logic             fwd_rs,
  output logic             fwd_rt,
  output logic             hazard_timeout,
  output logic [PERFW-1:0] stall_count,
  output sched_state_t     dbg_state
);

  // Wide enough to hold MAX_STALL+1 so "exceeds" is representable.
  localparam int SCW = $clog2(MAX_STALL + 2);
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  sched_state_t     state_q, state_d;
  logic [1:0]       flush_q, flush_d;
  logic [SCW-1:0]   consec_q, consec_d;
  logic [PERFW-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;

  logic rs_haz, rs_alu, rt_haz, rt_alu, hazard;

  hazard_chk u_chk_rs (
    .use_i      (id_rs_use),
    .adr_i      (id_rs_adr),
    .cnt_vec_i  (register_invalid),
    .haz_o      (rs_haz),
    .alu_pend_o (rs_alu)
  );

  hazard_chk u_chk_rt (
    .use_i      (id_rt_use),
    .adr_i      (id_rt_adr),
    .cnt_vec_i  (register_invalid),
    .haz_o      (rt_haz),
    .alu_pend_o (rt_alu)
  );

  assign hazard = id_valid && (rs_haz || rt_haz);

  // Next-state and issue/stall/flush decision; branch beats hazard.
  always_comb begin
    state_d      = state_q;
    flush_d      = flush_q;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    flush_decode = 1'b0;
    issue        = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN, STALL: begin
          if (branch_taken) begin
            flush_decode = 1'b1;
            if (FLUSH_CYCLES == 0) begin
              state_d = RUN;
            end else begin
              state_d = FLUSH;
              flush_d = FLUSH_LOAD;
            end
          end else if (hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            state_d  = STALL;
          end else begin
            issue   = id_valid;
            state_d = RUN;
          end
        end
        FLUSH: begin
          flush_decode = 1'b1;
          if (branch_taken) begin
            flush_d = FLUSH_LOAD;
            state_d = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
          end else if (flush_q <= 2'd1) begin
            flush_d = 2'd0;
            state_d = RUN;
          end else begin
            flush_d = flush_q - 2'd1;
          end
        end
        default: begin
          state_d = RUN;
          flush_d = 2'd0;
        end
      endcase
    end
  end

  // Scoreboard drive and forwarding flags follow the issue decision.
  always_comb begin
    regwrite_cur     = issue && id_regwrite;
    from_main_mem_id = id_from_mem;
    regwrite_adr_id  = id_rd_adr;
    fwd_rs           = FWD_EN && issue && rs_alu;
    fwd_rt           = FWD_EN && issue && rt_alu;
  end

  // Stall statistics: saturating totals, consecutive run and sticky timeout.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    consec_d    = '0;
    if (stall_id) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
      consec_d = (consec_q == '1) ? consec_q : consec_q + 1'b1;
    end
    timeout_d = timeout_q || (consec_d > SCW'(MAX_STALL));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      flush_q     <= 2'd0;
      consec_q    <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      consec_q    <= consec_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign hazard_timeout = timeout_q;
  assign stall_count    = stall_cnt_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched (FLUSH_CYCLES=1, MAX_STALL=7).
module tb_hazard_sched;
  import core_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         id_valid, id_rs_use, id_rt_use, id_regwrite, id_from_mem;
  reg_adr_t     id_rs_adr, id_rt_adr, id_rd_adr;
  logic         branch_taken;
  cnt_vec_t     register_invalid;
  logic         stall_if, stall_id, flush_decode, issue, regwrite_cur;
  logic         from_main_mem_id, fwd_rs, fwd_rt, hazard_timeout;
  reg_adr_t     regwrite_adr_id;
  logic [15:0]  stall_count;
  sched_state_t dbg_state;

  int errors = 0;
  int checks = 0;
  int exp_stalls = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp;

`ifdef HAZARD_SCHED_FORWARD_EN
  localparam int   LOAD_STALLS = 1;
  localparam logic FWD_BIT     = 1'b1;
`else
  localparam int   LOAD_STALLS = 2;
  localparam logic FWD_BIT     = 1'b0;
`endif

  // {stall_if, stall_id, flush_decode, issue, regwrite_cur, fwd_rs, fwd_rt}
  localparam logic [6:0] E_IDLE    = 7'b0000000;
  localparam logic [6:0] E_STALL   = 7'b1100000;
  localparam logic [6:0] E_FLUSH   = 7'b0010000;
  localparam logic [6:0] E_ISSUE   = 7'b0001000;
  localparam logic [6:0] E_ISSUE_W = 7'b0001100;

  wire [6:0] obs = {stall_if, stall_id, flush_decode, issue, regwrite_cur, fwd_rs, fwd_rt};

  hazard_sched #(.FLUSH_CYCLES(1), .MAX_STALL(7), .PERFW(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_rs_use        (id_rs_use),
    .id_rs_adr        (id_rs_adr),
    .id_rt_use        (id_rt_use),
    .id_rt_adr        (id_rt_adr),
    .id_regwrite      (id_regwrite),
    .id_from_mem      (id_from_mem),
    .id_rd_adr        (id_rd_adr),
    .branch_taken     (branch_taken),
    .register_invalid (register_invalid),
    .stall_if         (stall_if),
    .stall_id         (stall_id),
    .flush_decode     (flush_decode),
    .issue            (issue),
    .regwrite_cur     (regwrite_cur),
    .from_main_mem_id (from_main_mem_id),
    .regwrite_adr_id  (regwrite_adr_id),
    .fwd_rs           (fwd_rs),
    .fwd_rt           (fwd_rt),
    .hazard_timeout   (hazard_timeout),
    .stall_count      (stall_count),
    .dbg_state        (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic rsu, input int rs, input logic rtu,
                           input int rt, input logic rw, input logic fm, input int rd);
    id_valid    = v;
    id_rs_use   = rsu;
    id_rs_adr   = reg_adr_t'(rs);
    id_rt_use   = rtu;
    id_rt_adr   = reg_adr_t'(rt);
    id_regwrite = rw;
    id_from_mem = fm;
    id_rd_adr   = reg_adr_t'(rd);
  endtask

  task automatic push_exp(input logic [6:0] e);
    exp_q.push_back(e);
    if (e[5]) exp_stalls++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    register_invalid = '0;
    register_invalid[5] = 3'd3;
    set_instr(1, 1, 5, 1, 2, 1, 0, 3);
    next_cycle();
    next_cycle();
    push_exp(E_IDLE);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_outs: got %b expected %b", obs, exp); end
    checks++;
    if (dbg_state !== RUN) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, RUN); end
    checks++;
    if (stall_count !== 16'd0 || hazard_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_regs: stall_count=%0d timeout=%b expected 0/0", stall_count, hazard_timeout);
    end
    next_cycle();
    reset = 1'b0;
    register_invalid = '0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_issue();
    // Plain issue with a register write
    next_cycle();
    set_instr(1, 1, 1, 1, 2, 1, 0, 3);
    push_exp(E_ISSUE_W);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL issue_outs: got %b expected %b", obs, exp); end
    checks++;
    if (regwrite_adr_id !== 3'd3 || from_main_mem_id !== 1'b0) begin
      errors++; $display("FAIL issue_adr: got adr=%0d mem=%b expected 3/0", regwrite_adr_id, from_main_mem_id);
    end
    // No register write, load flag passthrough; unread pending register ignored
    next_cycle();
    register_invalid[5] = 3'd3;
    set_instr(1, 0, 5, 1, 0, 0, 1, 6);
    push_exp(E_ISSUE);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL issue_nowrite: got %b expected %b", obs, exp); end
    checks++;
    if (regwrite_adr_id !== 3'd6 || from_main_mem_id !== 1'b1) begin
      errors++; $display("FAIL issue_mem: got adr=%0d mem=%b expected 6/1", regwrite_adr_id, from_main_mem_id);
    end
    register_invalid = '0;
    // Random clean operands always issue
    for (int i = 0; i < 4; i++) begin
      int rd;
      next_cycle();
      rd = $urandom_range(0, 7);
      set_instr(1, 1, $urandom_range(0, 7), 1, $urandom_range(0, 7), 1, 0, rd);
      push_exp(E_ISSUE_W);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp || regwrite_adr_id !== reg_adr_t'(rd)) begin
        errors++; $display("FAIL issue_rand: got %b adr=%0d expected %b adr=%0d", obs, regwrite_adr_id, exp, rd);
      end
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      register_invalid = '0;
      register_invalid[2] = (i == 0) ? 3'd2 : (i == 1) ? 3'd1 : 3'd0;
      set_instr(1, 0, 0, 1, 2, 1, 0, 7);
      if (i < LOAD_STALLS) push_exp(E_STALL);
      else if (i == LOAD_STALLS) push_exp(E_ISSUE_W | {6'b0, FWD_BIT});
      else push_exp(E_ISSUE_W);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs, exp); end
      if (i == LOAD_STALLS) begin
        checks++;
        if (stall_count !== 16'(exp_stalls)) begin
          errors++; $display("FAIL load_stall_count: got %0d expected %0d", stall_count, exp_stalls);
        end
      end
    end
    register_invalid = '0;
  endtask

  task automatic test_branch_over_hazard();
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      register_invalid = '0;
      if (i < 2) register_invalid[4] = 3'd2;
      branch_taken = (i == 0);
      set_instr(1, 1, 4, 0, 0, 1, 0, 1);
      push_exp((i < 2) ? E_FLUSH : E_ISSUE_W);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL branch_hazard[%0d]: got %b expected %b", i, obs, exp); end
    end
    checks++;
    if (stall_count !== 16'(exp_stalls)) begin
      errors++; $display("FAIL branch_stall_count: got %0d expected %0d", stall_count, exp_stalls);
    end
    branch_taken = 1'b0;
    register_invalid = '0;
  endtask

  task automatic test_back_to_back_branch();
    // Second branch while flushing reloads the bubble counter
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      branch_taken = (i < 2);
      set_instr(1, 1, 1, 1, 2, 1, 0, 2);
      push_exp((i < 3) ? E_FLUSH : E_ISSUE_W);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL branch_reload[%0d]: got %b expected %b", i, obs, exp); end
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      register_invalid = '0;
      if (i < 9) register_invalid[5] = 3'd3;
      set_instr(1, 1, 5, 0, 0, 0, 0, 0);
      push_exp((i < 9) ? E_STALL : E_ISSUE);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL timeout_outs[%0d]: got %b expected %b", i, obs, exp); end
      checks++;
      if (hazard_timeout !== (i >= 8)) begin
        errors++; $display("FAIL timeout_flag[%0d]: got %b expected %b", i, hazard_timeout, (i >= 8));
      end
    end
    checks++;
    if (stall_count !== 16'(exp_stalls)) begin
      errors++; $display("FAIL timeout_stall_count: got %0d expected %0d", stall_count, exp_stalls);
    end
    register_invalid = '0;
  endtask

  task automatic test_reset_mid_stall();
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      register_invalid = '0;
      if (i < 4) register_invalid[5] = 3'd3;
      reset = (i == 2 || i == 3);
      set_instr(1, 1, 5, 0, 0, 1, 0, 4);
      if (i == 3) exp_stalls = 0;
      push_exp((i < 2) ? E_STALL : (i < 4) ? E_IDLE : E_ISSUE_W);
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_mid[%0d]: got %b expected %b", i, obs, exp); end
      if (i == 3) begin
        checks++;
        if (dbg_state !== RUN || stall_count !== 16'd0 || hazard_timeout !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_regs: state=%0d count=%0d timeout=%b expected 0/0/0",
                   dbg_state, stall_count, hazard_timeout);
        end
      end
    end
    reset = 1'b0;
    register_invalid = '0;
  endtask

  task automatic test_invalid();
    next_cycle();
    register_invalid[5] = 3'd3;
    set_instr(0, 1, 5, 1, 5, 1, 1, 6);
    push_exp(E_IDLE);
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL invalid_outs: got %b expected %b", obs, exp); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (dbg_state !== RUN || stall_count !== 16'(exp_stalls)) begin
      errors++; $display("FAIL invalid_state: state=%0d count=%0d expected %0d/%0d", dbg_state, stall_count, RUN, exp_stalls);
    end
    register_invalid = '0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_issue();
    test_load_use();
    test_branch_over_hazard();
    test_back_to_back_branch();
    test_timeout();
    test_reset_mid_stall();
    test_invalid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
